// File: rtl/dsi_rx_pkg.sv
// Shared types and helpers for the DSI receive packet layer:
// state encoding, header ECC columns, long-DT lookup and CRC-16 byte step.
package dsi_rx_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_PAYLOAD,
        S_CRC0,
        S_CRC1,
        S_DISCARD
    } state_t;

    localparam logic [15:0] CRC_INIT      = 16'hFFFF;
    localparam logic [15:0] CRC_POLY_REFL = 16'h8408;

    // Parity-bit pattern (P5..P0) contributed by each header data bit D23..D0.
    localparam logic [23:0][5:0] ECC_COL = {
        6'h3B, 6'h37, 6'h2F, 6'h1F, 6'h38, 6'h34, 6'h32, 6'h31,
        6'h2C, 6'h2A, 6'h29, 6'h26, 6'h25, 6'h23, 6'h1C, 6'h1A,
        6'h19, 6'h16, 6'h15, 6'h13, 6'h0E, 6'h0D, 6'h0B, 6'h07
    };

    function automatic logic [5:0] ecc_calc(input logic [23:0] d);
        logic [5:0] e;
        e = '0;
        for (int i = 0; i < 24; i++) begin
            if (d[i]) e = e ^ ECC_COL[i];
        end
        return e;
    endfunction

    function automatic logic is_long_dt(input logic [5:0] dt);
        return dt inside {6'h09, 6'h19, 6'h29, 6'h39,
                          6'h0C, 6'h1C, 6'h2C, 6'h3C,
                          6'h0E, 6'h1E, 6'h2E, 6'h3E};
    endfunction

    // Reflected CCITT, one byte, LSB first.
    function automatic logic [15:0] crc_step(input logic [15:0] crc,
                                             input logic [7:0]  b);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ b[i]) c = (c >> 1) ^ CRC_POLY_REFL;
            else             c = c >> 1;
        end
        return c;
    endfunction

endpackage

// File: rtl/dsi_rx_packet_parser_ecc.sv
// dsi_ecc_correct: combinational DSI header Hamming check/correct.
// Ports: data(24), ecc(8) in; fixed(24), corrected, error out.
module dsi_ecc_correct
    import dsi_rx_pkg::*;
(
    input  logic [23:0] data,
    input  logic [7:0]  ecc,
    output logic [23:0] fixed,
    output logic        corrected,
    output logic        error
);

    logic [5:0] syn;
    logic       hit;
    logic       one_bit;
    logic       unused_ecc_hi;

    // Bits 7:6 of the ECC byte are reserved and do not enter the syndrome.
    assign unused_ecc_hi = ^ecc[7:6];

    always_comb begin
        syn   = ecc_calc(data) ^ ecc[5:0];
        fixed = data;
        hit   = 1'b0;
        for (int i = 0; i < 24; i++) begin
            if (syn == ECC_COL[i]) begin
                fixed[i] = ~data[i];
                hit      = 1'b1;
            end
        end
        // A lone syndrome bit means the flip hit the ECC field itself.
        one_bit   = (syn != 6'd0) && ((syn & (syn - 6'd1)) == 6'd0);
        corrected = hit | one_bit;
        error     = (syn != 6'd0) && !hit && !one_bit;
    end

endmodule

// File: rtl/dsi_rx_packet_parser.sv
// DSI RX packet layer: header capture/ECC correct, payload stream, CRC-16 check.
// Ports: clk, reset_n, rx_* byte stream in; hdr_*, ecc_*, pl_*, pkt_done/errors out.
module dsi_rx_packet_parser #(
    parameter bit ACCEPT_ZERO_CRC = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_sop,
    input  logic        rx_eot,
    output logic        hdr_valid,
    output logic [7:0]  hdr_di,
    output logic [15:0] hdr_wc,
    output logic        hdr_long,
    output logic        ecc_corrected,
    output logic        ecc_error,
    output logic [7:0]  pl_data,
    output logic        pl_valid,
    output logic        pl_last,
    output logic        pkt_done,
    output logic        crc_error,
    output logic        len_error
);
    import dsi_rx_pkg::*;

    state_t      state, state_n;
    logic [1:0]  hcnt, hcnt_n;
    logic [7:0]  b0, b0_n, b1, b1_n, b2, b2_n;
    logic [15:0] wc_cnt, wc_n;
    logic [15:0] crc, crc_n;
    logic [7:0]  crc_lo, crc_lo_n;
    logic [7:0]  hdr_di_n, pl_data_n;
    logic [15:0] hdr_wc_n, rx_crc;
    logic        hdr_long_n, hdr_valid_n, ecc_corr_n, ecc_err_n;
    logic        pl_valid_n, pl_last_n, pkt_done_n, crc_err_n, len_err_n;
    logic        start;
    logic [23:0] fix;
    logic        fix_corr, fix_err;

    dsi_ecc_correct u_ecc (
        .data      ({b2, b1, b0}),
        .ecc       (rx_data),
        .fixed     (fix),
        .corrected (fix_corr),
        .error     (fix_err)
    );

    assign rx_crc = {rx_data, crc_lo};

    always_comb begin
        state_n     = state;
        hcnt_n      = hcnt;
        b0_n        = b0;
        b1_n        = b1;
        b2_n        = b2;
        wc_n        = wc_cnt;
        crc_n       = crc;
        crc_lo_n    = crc_lo;
        hdr_di_n    = hdr_di;
        hdr_wc_n    = hdr_wc;
        hdr_long_n  = hdr_long;
        pl_data_n   = pl_data;
        hdr_valid_n = 1'b0;
        ecc_corr_n  = 1'b0;
        ecc_err_n   = 1'b0;
        pl_valid_n  = 1'b0;
        pl_last_n   = 1'b0;
        pkt_done_n  = 1'b0;
        crc_err_n   = 1'b0;
        len_err_n   = 1'b0;
        start       = 1'b0;

        if (rx_eot) begin
            if (state inside {S_HDR, S_PAYLOAD, S_CRC0, S_CRC1}) begin
                pkt_done_n = 1'b1;
                len_err_n  = 1'b1;
            end
            state_n = S_IDLE;
        end else if (rx_valid) begin
            if (rx_sop && state != S_IDLE) begin
                // Restart: abort any open packet; DISCARD already reported.
                if (state != S_DISCARD) begin
                    pkt_done_n = 1'b1;
                    len_err_n  = 1'b1;
                end
                start = 1'b1;
            end else begin
                unique case (state)
                    S_IDLE: start = 1'b1;
                    S_HDR: begin
                        if (hcnt == 2'd1) begin
                            b1_n   = rx_data;
                            hcnt_n = 2'd2;
                        end else if (hcnt == 2'd2) begin
                            b2_n   = rx_data;
                            hcnt_n = 2'd3;
                        end else begin
                            hdr_valid_n = 1'b1;
                            hdr_di_n    = fix[7:0];
                            hdr_wc_n    = fix[23:8];
                            hdr_long_n  = is_long_dt(fix[5:0]);
                            ecc_corr_n  = fix_corr;
                            ecc_err_n   = fix_err;
                            wc_n        = fix[23:8];
                            if (fix_err) begin
                                state_n = S_DISCARD;
                            end else if (is_long_dt(fix[5:0])) begin
                                state_n = (fix[23:8] == 16'd0) ? S_CRC0
                                                               : S_PAYLOAD;
                            end else begin
                                pkt_done_n = 1'b1;
                                state_n    = S_IDLE;
                            end
                        end
                    end
                    S_PAYLOAD: begin
                        pl_data_n  = rx_data;
                        pl_valid_n = 1'b1;
                        crc_n      = crc_step(crc, rx_data);
                        wc_n       = wc_cnt - 16'd1;
                        if (wc_cnt == 16'd1) begin
                            pl_last_n = 1'b1;
                            state_n   = S_CRC0;
                        end
                    end
                    S_CRC0: begin
                        crc_lo_n = rx_data;
                        state_n  = S_CRC1;
                    end
                    S_CRC1: begin
                        crc_err_n  = (rx_crc != crc) &&
                                     !(ACCEPT_ZERO_CRC && rx_crc == 16'd0);
                        pkt_done_n = 1'b1;
                        state_n    = S_IDLE;
                    end
                    S_DISCARD: ;
                    default: state_n = S_IDLE;
                endcase
            end

            if (start) begin
                b0_n    = rx_data;
                hcnt_n  = 2'd1;
                crc_n   = CRC_INIT;
                state_n = S_HDR;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hcnt          <= 2'd0;
            b0            <= 8'd0;
            b1            <= 8'd0;
            b2            <= 8'd0;
            wc_cnt        <= 16'd0;
            crc           <= CRC_INIT;
            crc_lo        <= 8'd0;
            hdr_valid     <= 1'b0;
            hdr_di        <= 8'd0;
            hdr_wc        <= 16'd0;
            hdr_long      <= 1'b0;
            ecc_corrected <= 1'b0;
            ecc_error     <= 1'b0;
            pl_data       <= 8'd0;
            pl_valid      <= 1'b0;
            pl_last       <= 1'b0;
            pkt_done      <= 1'b0;
            crc_error     <= 1'b0;
            len_error     <= 1'b0;
        end else begin
            hcnt          <= hcnt_n;
            b0            <= b0_n;
            b1            <= b1_n;
            b2            <= b2_n;
            wc_cnt        <= wc_n;
            crc           <= crc_n;
            crc_lo        <= crc_lo_n;
            hdr_valid     <= hdr_valid_n;
            hdr_di        <= hdr_di_n;
            hdr_wc        <= hdr_wc_n;
            hdr_long      <= hdr_long_n;
            ecc_corrected <= ecc_corr_n;
            ecc_error     <= ecc_err_n;
            pl_data       <= pl_data_n;
            pl_valid      <= pl_valid_n;
            pl_last       <= pl_last_n;
            pkt_done      <= pkt_done_n;
            crc_error     <= crc_err_n;
            len_error     <= len_err_n;
        end
    end

endmodule

// File: tb/tb_dsi_rx_packet_parser.sv
// Directed bench for dsi_rx_packet_parser (two instances: zero-CRC accepted / rejected).
// Monitor tallies pulses at negedge; checks compare against hand-computed values.
module tb_dsi_rx_packet_parser;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        rx_sop = 1'b0;
    logic        rx_eot = 1'b0;

    logic        hdr_valid, hdr_long, ecc_corrected, ecc_error;
    logic [7:0]  hdr_di, pl_data;
    logic [15:0] hdr_wc;
    logic        pl_valid, pl_last, pkt_done, crc_error, len_error;

    logic        hdr_valid_z, hdr_long_z, ecc_corrected_z, ecc_error_z;
    logic [7:0]  hdr_di_z, pl_data_z;
    logic [15:0] hdr_wc_z;
    logic        pl_valid_z, pl_last_z, pkt_done_z, crc_error_z, len_error_z;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dsi_rx_packet_parser #(.ACCEPT_ZERO_CRC(1'b1)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_sop(rx_sop), .rx_eot(rx_eot),
        .hdr_valid(hdr_valid), .hdr_di(hdr_di), .hdr_wc(hdr_wc), .hdr_long(hdr_long),
        .ecc_corrected(ecc_corrected), .ecc_error(ecc_error),
        .pl_data(pl_data), .pl_valid(pl_valid), .pl_last(pl_last),
        .pkt_done(pkt_done), .crc_error(crc_error), .len_error(len_error)
    );

    dsi_rx_packet_parser #(.ACCEPT_ZERO_CRC(1'b0)) u_dut_z (
        .clk(clk), .reset_n(reset_n),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_sop(rx_sop), .rx_eot(rx_eot),
        .hdr_valid(hdr_valid_z), .hdr_di(hdr_di_z), .hdr_wc(hdr_wc_z),
        .hdr_long(hdr_long_z),
        .ecc_corrected(ecc_corrected_z), .ecc_error(ecc_error_z),
        .pl_data(pl_data_z), .pl_valid(pl_valid_z), .pl_last(pl_last_z),
        .pkt_done(pkt_done_z), .crc_error(crc_error_z), .len_error(len_error_z)
    );

    // Monitor state
    int          n_hdr, n_pl, n_last, n_done, n_len, pl_sum;
    logic [7:0]  m_di, m_last_byte;
    logic [15:0] m_wc;
    logic        m_long, m_corr, m_err, d_crc, d_len, d_crc_z, or_crc, or_len;

    task automatic clr();
        n_hdr = 0; n_pl = 0; n_last = 0; n_done = 0; n_len = 0; pl_sum = 0;
        m_di = 0; m_wc = 0; m_long = 0; m_corr = 0; m_err = 0; m_last_byte = 0;
        d_crc = 0; d_len = 0; d_crc_z = 0; or_crc = 0; or_len = 0;
    endtask

    always @(negedge clk) begin
        if (hdr_valid) begin
            n_hdr++;
            m_di = hdr_di; m_wc = hdr_wc; m_long = hdr_long;
            m_corr = ecc_corrected; m_err = ecc_error;
        end
        if (pl_valid) begin
            n_pl++;
            pl_sum += int'(pl_data);
            if (pl_last) begin
                n_last++;
                m_last_byte = pl_data;
            end
        end
        if (pkt_done) begin
            n_done++;
            d_crc = crc_error; d_len = len_error;
            or_crc |= crc_error; or_len |= len_error;
            if (len_error) n_len++;
        end
        if (pkt_done_z) d_crc_z = crc_error_z;
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic put(input logic [7:0] b, input logic sop);
        @(negedge clk);
        rx_data = b; rx_valid = 1'b1; rx_sop = sop; rx_eot = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_valid = 1'b0; rx_sop = 1'b0; rx_eot = 1'b0;
        end
    endtask

    task automatic eot();
        @(negedge clk);
        rx_valid = 1'b0; rx_sop = 1'b0; rx_eot = 1'b1;
        @(negedge clk);
        rx_eot = 1'b0;
    endtask

    task automatic hdr4(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [7:0] e,
                        input logic sop);
        put(a, sop); put(b, 1'b0); put(c, 1'b0); put(e, 1'b0);
    endtask

    task automatic payload(input int n);
        for (int i = 0; i < n; i++) put(8'h31 + 8'(i), 1'b0);
    endtask

    initial begin
        clr();
        repeat (3) @(negedge clk);
        check("reset_out",
              {hdr_valid, hdr_di, hdr_wc, hdr_long, ecc_corrected, ecc_error,
               pl_data, pl_valid, pl_last, pkt_done, crc_error, len_error},
              64'd0);
        reset_n = 1'b1;
        gap(2);

        // Good long packet "123456789", CRC 0x6F91
        clr();
        hdr4(8'h39, 8'h09, 8'h00, 8'h30, 1'b1);
        payload(9);
        put(8'h91, 1'b0); put(8'h6F, 1'b0);
        eot(); gap(3);
        check("long_nhdr", n_hdr, 1);
        check("long_wc", m_wc, 16'd9);
        check("long_long", m_long, 1);
        check("long_corr", {m_corr, m_err}, 0);
        check("long_npl", n_pl, 9);
        check("long_sum", pl_sum, 477);
        check("long_last", {8'(n_last), m_last_byte}, {8'd1, 8'h39});
        check("long_done", {8'(n_done), d_crc, d_len}, {8'd1, 2'b00});

        // Single data-bit correction (WC bit 8)
        clr();
        hdr4(8'h39, 8'h02, 8'h00, 8'h09, 1'b1);
        gap(2);
        check("fix_data", {m_corr, m_err, m_di, m_wc}, {2'b10, 8'h39, 16'h0003});
        eot(); gap(2);
        check("fix_data_eot", {8'(n_done), d_len}, {8'd1, 1'b1});

        // ECC-field single-bit error
        clr();
        hdr4(8'h39, 8'h03, 8'h00, 8'h0B, 1'b1);
        gap(2);
        check("fix_ecc", {m_corr, m_err, m_wc}, {2'b10, 16'h0003});
        eot(); gap(2);

        // Uncorrectable header then discarded bytes
        clr();
        hdr4(8'h39, 8'h03, 8'h00, 8'h0F, 1'b1);
        put(8'h11, 1'b0); put(8'h22, 1'b0); put(8'h33, 1'b0); put(8'h44, 1'b0);
        eot(); gap(3);
        check("ecc_err", {8'(n_hdr), m_err}, {8'd1, 1'b1});
        check("ecc_err_drop", {8'(n_pl), 8'(n_done)}, 16'd0);

        // Zero CRC on both instances
        clr();
        hdr4(8'h39, 8'h09, 8'h00, 8'h30, 1'b1);
        payload(9);
        put(8'h00, 1'b0); put(8'h00, 1'b0);
        eot(); gap(3);
        check("zero_crc_acc", {8'(n_done), d_crc}, {8'd1, 1'b0});
        check("zero_crc_rej", d_crc_z, 1);

        // Bad CRC
        clr();
        hdr4(8'h39, 8'h09, 8'h00, 8'h30, 1'b1);
        payload(9);
        put(8'h92, 1'b0); put(8'h6F, 1'b0);
        eot(); gap(3);
        check("bad_crc", {8'(n_done), d_crc, d_len}, {8'd1, 2'b10});
        check("bad_crc_z", d_crc_z, 1);

        // Truncated burst
        clr();
        hdr4(8'h39, 8'h09, 8'h00, 8'h30, 1'b1);
        payload(4);
        eot(); gap(3);
        check("trunc", {8'(n_pl), 8'(n_done), d_len, d_crc},
              {8'd4, 8'd1, 2'b10});

        // Short packet with a 3-cycle gap inside
        clr();
        put(8'h05, 1'b1); put(8'h11, 1'b0); gap(3);
        put(8'h00, 1'b0); put(8'h36, 1'b0);
        gap(3);
        check("short_hdr", {8'(n_hdr), m_di, m_wc, m_long, m_corr, m_err},
              {8'd1, 8'h05, 16'h0011, 3'b000});
        check("short_done", {8'(n_done), d_len, d_crc}, {8'd1, 2'b00});
        eot(); gap(2);

        // Back-to-back short, long, WC=0 long in one burst
        clr();
        hdr4(8'h05, 8'h11, 8'h00, 8'h36, 1'b1);
        hdr4(8'h39, 8'h09, 8'h00, 8'h30, 1'b0);
        payload(9);
        put(8'h91, 1'b0); put(8'h6F, 1'b0);
        hdr4(8'h39, 8'h00, 8'h00, 8'h0F, 1'b0);
        put(8'hFF, 1'b0); put(8'hFF, 1'b0);
        eot(); gap(3);
        check("b2b_cnt", {8'(n_hdr), 8'(n_done), 8'(n_pl)},
              {8'd3, 8'd3, 8'd9});
        check("b2b_err", {or_crc, or_len, m_err}, 0);
        check("wc0_hdr", {m_wc, m_long}, {16'd0, 1'b1});

        // rx_sop restart mid-payload
        clr();
        hdr4(8'h39, 8'h09, 8'h00, 8'h30, 1'b1);
        payload(2);
        hdr4(8'h05, 8'h11, 8'h00, 8'h36, 1'b1);
        gap(3);
        check("sop_abort", {8'(n_hdr), 8'(n_done), 8'(n_len), m_long, d_len},
              {8'd2, 8'd2, 8'd1, 2'b00});
        eot(); gap(2);

        // Reset mid-packet
        clr();
        hdr4(8'h39, 8'h09, 8'h00, 8'h30, 1'b1);
        payload(2);
        @(negedge clk);
        rx_valid = 1'b0;
        reset_n  = 1'b0;
        #1;
        check("rst_mid_out",
              {hdr_valid, hdr_di, hdr_wc, hdr_long, pl_data, pl_valid,
               pkt_done, len_error},
              64'd0);
        gap(2);
        reset_n = 1'b1;
        check("rst_mid_nodone", n_done, 0);
        clr();
        hdr4(8'h05, 8'h11, 8'h00, 8'h36, 1'b0);
        gap(3);
        check("rst_after", {8'(n_hdr), 8'(n_done), d_len, m_wc},
              {8'd1, 8'd1, 1'b0, 16'h0011});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dsi_rx_packet_parser.md
# dsi_rx_packet_parser

Receive-side DSI packet layer. It consumes the de-lane-merged HS byte stream, captures the 4-byte packet header, and checks and corrects it with the 6-bit Hamming ECC. For long packets it streams the payload out and verifies the trailing CRC-16. It is the counterpart of the transmit-side ECC/CRC generators and sits between the D-PHY lane merger and the command/pixel sinks.

## Interface
- ACCEPT_ZERO_CRC, 1: received CRC 0x0000 is treated as "not computed"; no crc_error.
- clk  in  1  core clock
- reset_n  in  1  reset, asynchronous, active-low
- rx_data  in  8  received byte
- rx_valid  in  1  rx_data valid this cycle; no backpressure exists
- rx_sop  in  1  first byte of an HS burst (qualified by rx_valid); forces header restart
- rx_eot  in  1  end of HS burst pulse; may coincide with rx_valid=0 only
- hdr_valid  out  1  one-cycle pulse: header decoded
- hdr_di  out  8  corrected data identifier
- hdr_wc  out  16  corrected word count (short packet: data0/data1)
- hdr_long  out  1  DT is a long-packet type
- ecc_corrected  out  1  single-bit error fixed (valid with hdr_valid)
- ecc_error  out  1  uncorrectable header (valid with hdr_valid)
- pl_data  out  8  payload byte
- pl_valid  out  1  pl_data valid
- pl_last  out  1  final payload byte
- pkt_done  out  1  one-cycle pulse: packet finished or aborted
- crc_error  out  1  valid with pkt_done; CRC mismatch
- len_error  out  1  valid with pkt_done; burst ended or restarted mid-packet

## Operation
- FSM: IDLE, HDR, PAYLOAD, CRC0, CRC1, DISCARD.
- IDLE: any valid byte is header byte 0 -> HDR (byte counter = 1). rx_sop is not required; packets are back-to-back within a burst.
- HDR: stores bytes 0..2. Byte 3 = ECC. Syndrome = ecc(bytes0..2)[5:0] ^ ecc_byte[5:0].
  - Syndrome 0: header accepted.
  - Syndrome equals one of the 24 data-bit columns: flip that bit, ecc_corrected=1.
  - Syndrome has exactly one bit set: error is in the ECC field, header accepted, ecc_corrected=1.
  - Anything else: ecc_error=1 -> DISCARD.
- Long DT (DI[5:0] in {09,19,29,39,0C,1C,2C,3C,0E,1E,2E,3E}): WC>0 -> PAYLOAD; WC=0 -> CRC0. Short DT: pkt_done -> IDLE.
- PAYLOAD: each byte is forwarded and updates the CRC. WC is decremented per byte. The byte where WC reaches 1 carries pl_last -> CRC0.
- CRC: reflected CCITT, poly 0x8408, init 0xFFFF, no final XOR, LSB-first per byte. The received CRC arrives as CRC0 (low byte), then CRC1 (high byte). At CRC1: crc_error = (rx != calc) && !(ACCEPT_ZERO_CRC && rx==0). Then pkt_done -> IDLE.
- DISCARD: drops bytes until rx_eot or rx_sop. No pkt_done is issued (hdr_valid with ecc_error already reported).
- rx_eot in HDR/PAYLOAD/CRC0/CRC1: pkt_done with len_error=1 -> IDLE. rx_eot in IDLE is ignored.
- rx_sop in any non-IDLE state other than DISCARD: the current packet is aborted (pkt_done, len_error=1) and the sop byte becomes header byte 0 in the same cycle.
- Simultaneous rx_sop and the CRC1 byte is impossible by construction: the sop byte is header byte 0, not CRC1.

## Timing
- All outputs are registered. Reset value of every output is 0, state is IDLE, CRC register is 0xFFFF.
- hdr_valid, hdr_* and ecc_* assert the cycle after the ECC byte is accepted. hdr_di/hdr_wc/hdr_long hold until the next hdr_valid.
- pl_data/pl_valid lag rx_data by 1 cycle. pl_valid is asserted only in cycles following rx_valid.
- pkt_done asserts 1 cycle after CRC1 is accepted, after the ECC byte (short packet), or after the rx_eot/rx_sop abort.
- The first payload byte may arrive the cycle immediately after the ECC byte. It uses the registered corrected WC.
- Gaps (rx_valid=0) are allowed anywhere. State, counters and CRC hold during gaps.
- Reset mid-packet: immediate return to IDLE and all outputs 0. There is no pkt_done.

## Structure
- Package dsi_rx_pkg holds:
  - the long-DT list function
  - the ECC column constants (24 × 6-bit)
  - CRC_INIT=16'hFFFF and CRC_POLY_REFL=16'h8408
  - the state enum
- Sub-module dsi_ecc_correct: combinational; 24-bit data + 8-bit ECC in -> corrected 24-bit data, corrected, error out. Shared with the future loopback checker.
- The CRC byte step is a function in dsi_rx_pkg.

## Test plan
- Header 39 09 00 30 with payload "123456789" and CRC bytes 91 6F -> hdr_wc=9, hdr_long=1, 9 pl_valid with pl_last on '9', pkt_done with crc_error=0, len_error=0.
- Header 39 02 00 09 (WC bit 8 flipped, syndrome 0x1A) -> ecc_corrected=1, hdr_wc=0x0003.
- Header 39 03 00 0B (ECC bit 1 flipped) -> ecc_corrected=1, hdr_wc=3. Header 39 03 00 0F -> ecc_error=1, subsequent bytes dropped until rx_eot, no pl_valid.
- Same long packet with CRC 00 00: ACCEPT_ZERO_CRC=1 -> crc_error=0; ACCEPT_ZERO_CRC=0 -> crc_error=1. CRC 92 6F -> crc_error=1.
- rx_eot after 4 of 9 payload bytes -> pkt_done with len_error=1, IDLE. A following short packet 05 11 00 ECC with a 3-cycle rx_valid gap inside -> hdr_valid, pkt_done, no errors.
- Back-to-back short then long packet in one burst without rx_sop, plus long packet with WC=0 (header 39 00 00 ECC, CRC FF FF) -> both decoded; the WC=0 packet has no pl_valid and crc_error=0.
